hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 16-bit five-stage CPU (fetch, decode, execute, memory, write-back). It tracks the destination registers of in-flight instructions in its own shadow pipeline and drives four groups of signals:
- the PC and IF/ID write enables;
- the IF/ID, ID/EX and EX/MEM bubble (flush) controls;
- the execute-stage operand forwarding selects;
- a multi-cycle execute hold for multiply/divide instructions, which write R15.

It sits beside the decode-stage `control` block and replaces the constant enables and selects currently tied off in `cpu`.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Decode-stage hazard request / pipeline control bundle between
//               the CPU datapath (master) and hazard_ctrl (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_use1;
    logic       id_use2;
    logic [3:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_muldiv;
    logic       branch_taken;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_we;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       busy;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, id_rd, id_reg_write,
               id_mem_read, id_muldiv, branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
               fwd_a_sel, fwd_b_sel, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, id_rd, id_reg_write,
               id_mem_read, id_muldiv, branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
               fwd_a_sel, fwd_b_sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/forwarding/mul-div hold controller for the 5-stage
//               16-bit CPU. Define HAZARD_FWD_EN to enable EX forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_MULDIV = 2'd1;
    localparam int         c_LOAD_VAL  = (MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0;
    localparam logic [3:0] c_CNT_LOAD  = 4'(c_LOAD_VAL);
    localparam logic       c_HOLD_EN   = (MULDIV_CYCLES > 1);

    function automatic logic f_reads(input logic u1, input logic [3:0] s1,
                                     input logic u2, input logic [3:0] s2,
                                     input logic [3:0] rd);
        return (u1 && (s1 == rd)) || (u2 && (s2 == rd));
    endfunction

    logic [1:0] r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       w_md_clr;
    logic [3:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic       r_ex_rw, r_ex_mr, r_ex_md, r_mem_rw, r_wb_rw;
    logic       w_hold, w_stall, w_id_hit_ex;
    logic       w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_flush;
    logic       w_exmem_flush, w_busy;

    // The mul/div is held from its first EX cycle; the FSM covers the rest.
    assign w_hold      = (r_state == c_ST_MULDIV) || (c_HOLD_EN && r_ex_md);
    assign w_id_hit_ex = f_reads(hz.id_use1, hz.id_rs1, hz.id_use2, hz.id_rs2, r_ex_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_clr    = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (c_HOLD_EN && r_ex_md) begin
                    w_cnt_nxt = c_CNT_LOAD;
                    if (c_CNT_LOAD == 4'd0) begin
                        w_md_clr = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_MULDIV;
                    end
                end
            end
            c_ST_MULDIV: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_ST_RUN;
                    w_md_clr    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_we     = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_busy        = 1'b0;
        if (w_hold) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_exmem_flush = 1'b1;
            w_busy        = 1'b1;
        end else if (w_stall) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
        end else begin
            w_ifid_flush = hz.branch_taken;
        end
    end

    assign hz.pc_we       = w_pc_we;
    assign hz.ifid_we     = w_ifid_we;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_we     = w_idex_we;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_flush = w_exmem_flush;
    assign hz.busy        = w_busy;

    // A stall loads ID/EX with a bubble, so idex_flush always comes with idex_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd  <= 4'd0;
            r_ex_rw  <= 1'b0;
            r_ex_mr  <= 1'b0;
            r_ex_md  <= 1'b0;
            r_mem_rd <= 4'd0;
            r_mem_rw <= 1'b0;
            r_wb_rd  <= 4'd0;
            r_wb_rw  <= 1'b0;
        end else begin
            if (w_idex_we) begin
                r_ex_rd <= hz.id_rd;
                r_ex_rw <= hz.id_reg_write & ~w_idex_flush;
                r_ex_mr <= hz.id_mem_read  & ~w_idex_flush;
                r_ex_md <= hz.id_muldiv    & ~w_idex_flush;
            end else if (w_md_clr) begin
                r_ex_md <= 1'b0;
            end
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw & ~w_exmem_flush;
            r_wb_rd  <= r_mem_rd;
            r_wb_rw  <= r_mem_rw;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [3:0] r_ex_rs1, r_ex_rs2;
    logic       r_ex_use1, r_ex_use2, r_mem_mr;

    function automatic logic [1:0] f_fwd(input logic use_en, input logic [3:0] src,
                                         input logic mem_rw, input logic mem_mr,
                                         input logic [3:0] mem_rd,
                                         input logic wb_rw, input logic [3:0] wb_rd);
        if (!use_en)                               return 2'b00;
        else if (mem_rw && !mem_mr && mem_rd == src) return 2'b10;
        else if (wb_rw && wb_rd == src)            return 2'b01;
        else                                       return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs1  <= 4'd0;
            r_ex_rs2  <= 4'd0;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
            r_mem_mr  <= 1'b0;
        end else begin
            if (w_idex_we) begin
                r_ex_rs1  <= hz.id_rs1;
                r_ex_rs2  <= hz.id_rs2;
                r_ex_use1 <= hz.id_use1 & ~w_idex_flush;
                r_ex_use2 <= hz.id_use2 & ~w_idex_flush;
            end
            r_mem_mr <= r_ex_mr & ~w_exmem_flush;
        end
    end

    assign w_stall      = r_ex_mr && w_id_hit_ex;
    assign hz.fwd_a_sel = f_fwd(r_ex_use1, r_ex_rs1, r_mem_rw, r_mem_mr, r_mem_rd, r_wb_rw, r_wb_rd);
    assign hz.fwd_b_sel = f_fwd(r_ex_use2, r_ex_rs2, r_mem_rw, r_mem_mr, r_mem_rd, r_wb_rw, r_wb_rd);
`else
    logic w_id_hit_mem, w_id_hit_wb;

    // Without forwarding a reader waits until its writer has left WB.
    assign w_id_hit_mem = f_reads(hz.id_use1, hz.id_rs1, hz.id_use2, hz.id_rs2, r_mem_rd);
    assign w_id_hit_wb  = f_reads(hz.id_use1, hz.id_rs1, hz.id_use2, hz.id_rs2, r_wb_rd);
    assign w_stall      = (r_ex_mr && w_id_hit_ex) || (r_ex_rw && w_id_hit_ex) ||
                          (r_mem_rw && w_id_hit_mem) || (r_wb_rw && w_id_hit_wb);
    assign hz.fwd_a_sel = 2'b00;
    assign hz.fwd_b_sel = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//               randomized traffic against an instruction-level pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int C = 4;
    localparam logic [10:0] c_IDLE = 11'b11010000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MULDIV_CYCLES(C)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct packed {
        logic       rw, mr, md, u1, u2;
        logic [3:0] rd, rs1, rs2;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_age;
    logic m_hold, m_stall;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic ins_t id_ins();
        ins_t d;
        d.rw = hz.id_reg_write; d.mr = hz.id_mem_read; d.md = hz.id_muldiv;
        d.u1 = hz.id_use1; d.u2 = hz.id_use2;
        d.rd = hz.id_rd; d.rs1 = hz.id_rs1; d.rs2 = hz.id_rs2;
        return d;
    endfunction

    function automatic logic reads(ins_t d, logic [3:0] r);
        return (d.u1 && d.rs1 == r) || (d.u2 && d.rs2 == r);
    endfunction

    function automatic logic [1:0] fsel(logic u, logic [3:0] src);
`ifdef HAZARD_FWD_EN
        if (!u) return 2'b00;
        if (m_mem.rw && !m_mem.mr && m_mem.rd == src) return 2'b10;
        if (m_wb.rw && m_wb.rd == src) return 2'b01;
        return 2'b00;
`else
        return (u && src == 4'hF && src != 4'hF) ? 2'b11 : 2'b00;
`endif
    endfunction

    function automatic logic [10:0] dut_vec();
        return {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
                hz.exmem_flush, hz.busy, hz.fwd_a_sel, hz.fwd_b_sel};
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_age = 1; m_hold = 1'b0; m_stall = 1'b0;
    endtask

    task automatic model_out(output logic [10:0] e);
        ins_t d = id_ins();
        logic go;
        // A mul/div occupies EX for C cycles; it is frozen for all but the last.
        m_hold  = m_ex.md && (C > 1) && (m_age < C);
        m_stall = m_ex.mr && reads(d, m_ex.rd);
`ifndef HAZARD_FWD_EN
        m_stall = m_stall || (m_ex.rw && reads(d, m_ex.rd)) ||
                  (m_mem.rw && reads(d, m_mem.rd)) || (m_wb.rw && reads(d, m_wb.rd));
`endif
        go = !m_hold && !m_stall;
        e = {go, go, go && hz.branch_taken, !m_hold, !m_hold && m_stall, m_hold, m_hold,
             fsel(m_ex.u1, m_ex.rs1), fsel(m_ex.u2, m_ex.rs2)};
    endtask

    task automatic model_step();
        ins_t d = id_ins();
        m_wb = m_mem;
        if (m_hold) begin
            m_mem = '0;
            m_age++;
        end else begin
            m_mem = m_ex;
            m_ex  = m_stall ? '0 : d;
            m_age = 1;
        end
    endtask

    task automatic tick(output logic [10:0] g);
        logic [10:0] e;
        @(negedge clk);
        cyc++;
        g = dut_vec();
        if (!rst) begin
            model_out(e);
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL cycle %0d outputs: got %b expected %b", cyc, g, e);
            model_step();
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [10:0] got, logic [10:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic set_id(logic [3:0] rs1, logic u1, logic [3:0] rs2, logic u2,
                          logic [3:0] rd, logic rw, logic mr, logic md, logic br);
        hz.id_rs1 = rs1; hz.id_use1 = u1; hz.id_rs2 = rs2; hz.id_use2 = u2;
        hz.id_rd = rd; hz.id_reg_write = rw; hz.id_mem_read = mr;
        hz.id_muldiv = md; hz.branch_taken = br;
    endtask

    task automatic nop();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [3:0] pick_reg();
        int unsigned r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        logic [10:0] g;
        int unsigned k;
        model_reset();
        rst = 1'b1;
        nop();
        repeat (2) tick(g);
        rst = 1'b0;
        tick(g);
        chk("reset", g, c_IDLE);

        // Load R3 then a reader of R3
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0); tick(g);
        set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        chk("lu_stall", g, 11'b00011000000);
`ifdef HAZARD_FWD_EN
        tick(g);
        chk("lu_release", g, c_IDLE);
        nop(); tick(g);
        chk("lu_fwd_a", g, 11'b11010000100);

        // ALU write R5, reader of R5 on rs2, directly and with one gap
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        chk("alu_nostall", g, c_IDLE);
        nop(); tick(g);
        chk("alu_fwd_b_mem", g, 11'b11010000010);
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        nop(); tick(g);
        chk("alu_fwd_b_wb", g, 11'b11010000001);
`else
        repeat (2) tick(g);
        tick(g);
        chk("lu_release", g, c_IDLE);
        nop(); tick(g);

        // ALU write R2, reader of R2: three stall cycles
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick(g);
        set_id(4'd2, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(g);
            chk("raw_stall", g, 11'b00011000000);
        end
        tick(g);
        chk("raw_release", g, c_IDLE);
        nop(); tick(g);
        chk("raw_fwd_zero", g, c_IDLE);
`endif

        // Branch during a load-use stall is ignored, honoured once unstalled
        nop(); tick(g);
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0); tick(g);
        set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1); tick(g);
        chk("br_in_stall", {g[10], g[8]}, 11'd0);
`ifndef HAZARD_FWD_EN
        repeat (2) tick(g);
`endif
        tick(g);
        chk("br_unstalled", {g[10], g[8]}, 11'b11);

        // Mul/div hold: three held cycles then release
        nop(); tick(g);
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0); tick(g);
        nop();
        for (int i = 0; i < 3; i++) begin
            tick(g);
            chk("md_hold", {g[10], g[9], g[7], g[5], g[4]}, 11'b00011);
        end
        tick(g);
        chk("md_release", {g[10], g[9], g[7], g[5], g[4]}, 11'b11100);

        // Reset in the second hold cycle aborts the hold
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0); tick(g);
        nop(); tick(g);
        chk("md_abort_pre", g[4], 11'd1);
        rst = 1'b1; tick(g);
        rst = 1'b0; tick(g);
        chk("md_abort", g, c_IDLE);

        // Randomized traffic; ID is held while the model says it is stalled
        for (int i = 0; i < 3000; i++) begin
            if (!(m_stall || m_hold)) begin
                k = $urandom_range(0, 9);
                hz.id_muldiv    = (k == 0);
                hz.id_mem_read  = (k >= 1 && k <= 3);
                hz.id_reg_write = (k <= 7);
                hz.id_rd        = (k == 0) ? 4'd15 : pick_reg();
                hz.id_rs1       = pick_reg();
                hz.id_rs2       = pick_reg();
                hz.id_use1      = 1'($urandom_range(0, 1));
                hz.id_use2      = 1'($urandom_range(0, 1));
            end
            hz.branch_taken = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick(g);
        end
        rst = 1'b0;
        nop();
        tick(g);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
